sysid_ctrl: RTL and testbench

Controller for the 2-word system-ID slave: address 0 returns the 32-bit ID and address 1 returns the 32-bit build timestamp, both combinational.
- Automatically reads and checks both words after reset, and again on request or periodically.
- Shares the slave's single address/readdata path with one host Avalon-style read master.
- Exposes ok/mismatch status, which the firmware loader gates on.

---
 rtl/sysid_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sysid_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sysid_ctrl.sv
// System-ID checker: reads ID/timestamp words after reset, on start or periodically, and shares the slave with a host reader.
// Check latency: busy for 2*SETTLE+1 cycles, done pulses one cycle later; host read data is valid 2 cycles after accept.
// Host reads are stalled by host_waitrequest while a check is pending or running; start during a check is latched once.
module sysid_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd364094772,
  parameter logic [31:0] EXPECTED_TS    = 32'd1426599870,
  parameter int          SETTLE         = 1,
  parameter int          RECHECK_PERIOD = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        host_read,
  input  logic        host_address,
  output logic        host_waitrequest,
  output logic        host_readdatavalid,
  output logic [31:0] host_readdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        checked,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        mismatch,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [23:0] PERIOD    = 24'(RECHECK_PERIOD);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    COMPARE,
    HOST_RD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        check_req;
  logic [3:0]  settle_cnt;
  logic [23:0] timer;
  logic        tmr_hit;
  logic        req;
  logic        go;
  logic        host_go;
  logic        settle_last;

  // A request can come from the pending flag, a start pulse this cycle or the
  // period timer expiring this cycle; the latter two act immediately so a
  // start at T makes the check busy from T+1.
  assign tmr_hit     = (timer == 24'd1);
  assign req         = check_req | start | tmr_hit;
  assign settle_last = (settle_cnt == 4'd0);

  assign busy             = (state == RD_ID) | (state == RD_TS) | (state == COMPARE);
  assign host_waitrequest = !((state == IDLE) && !req);
  assign mismatch         = checked & !(id_ok & ts_ok);

  // Next-state logic: a pending check always wins over the host.
  always_comb begin
    state_n = state;
    go      = 1'b0;
    host_go = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = RD_ID;
          go      = 1'b1;
        end else if (host_read) begin
          state_n = HOST_RD;
          host_go = 1'b1;
        end
      end
      RD_ID:   if (settle_last) state_n = RD_TS;
      RD_TS:   if (settle_last) state_n = COMPARE;
      COMPARE: state_n = IDLE;
      HOST_RD: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Single pending-request flag; reset leaves a check queued.
  always_ff @(posedge clk) begin
    if (reset) check_req <= 1'b1;
    else       check_req <= (check_req | start | tmr_hit) & !go;
  end

  // Period timer: idle at zero until the first check completes, reloads at each compare.
  always_ff @(posedge clk) begin
    if (reset)                 timer <= 24'd0;
    else if (state == COMPARE) timer <= PERIOD;
    else if (timer != 24'd0)   timer <= timer - 24'd1;
  end

  // Slave address, settle counter and captured words.
  always_ff @(posedge clk) begin
    if (reset) begin
      sid_address <= 1'b0;
      settle_cnt  <= 4'd0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            sid_address <= 1'b0;
            settle_cnt  <= SETTLE_M1;
          end else if (host_go) begin
            sid_address <= host_address;
          end
        end
        RD_ID: begin
          if (settle_last) begin
            id_value    <= sid_readdata;
            sid_address <= 1'b1;
            settle_cnt  <= SETTLE_M1;
          end else begin
            settle_cnt  <= settle_cnt - 4'd1;
          end
        end
        RD_TS: begin
          if (settle_last) ts_value   <= sid_readdata;
          else             settle_cnt <= settle_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Status flags update only at compare and hold between checks.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_ok   <= 1'b0;
      ts_ok   <= 1'b0;
      checked <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == COMPARE);
      if (state == COMPARE) begin
        id_ok   <= (id_value == EXPECTED_ID);
        ts_ok   <= (ts_value == EXPECTED_TS);
        checked <= 1'b1;
      end
    end
  end

  // Host read return path: capture in HOST_RD, flag valid the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_readdatavalid <= 1'b0;
      host_readdata      <= 32'd0;
    end else begin
      host_readdatavalid <= (state == HOST_RD);
      if (state == HOST_RD) host_readdata <= sid_readdata;
    end
  end

endmodule

// File: tb/tb_sysid_ctrl.sv
// Directed bench for sysid_ctrl: one instance without periodic recheck, one with a 100-cycle period.
// Inputs are driven 1 time unit after the rising edge; outputs are checked there too.
// Every check is an immediate assertion that counts failures.
module tb_sysid_ctrl;

  localparam logic [31:0] EXP_ID = 32'd364094772;
  localparam logic [31:0] EXP_TS = 32'd1426599870;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance 0 (no recheck)
  logic        rst0, sa0, hrd0, haddr0, hwait0, hrdv0, start0;
  logic        busy0, done0, checked0, idok0, tsok0, mism0;
  logic [31:0] rd0, hrdata0, idv0, tsv0, id0w, ts0w;
  // instance 1 (RECHECK_PERIOD=100)
  logic        rst1, sa1, hrd1, haddr1, hwait1, hrdv1, start1;
  logic        busy1, done1, checked1, idok1, tsok1, mism1;
  logic [31:0] rd1, hrdata1, idv1, tsv1;

  // behavioural two-word slaves
  assign rd0 = sa0 ? ts0w : id0w;
  assign rd1 = sa1 ? EXP_TS : EXP_ID;

  sysid_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .SETTLE(1), .RECHECK_PERIOD(0)) dut0 (
    .clk(clk), .reset(rst0), .sid_address(sa0), .sid_readdata(rd0),
    .host_read(hrd0), .host_address(haddr0), .host_waitrequest(hwait0),
    .host_readdatavalid(hrdv0), .host_readdata(hrdata0), .start(start0),
    .busy(busy0), .done(done0), .checked(checked0), .id_ok(idok0), .ts_ok(tsok0),
    .mismatch(mism0), .id_value(idv0), .ts_value(tsv0)
  );

  sysid_ctrl #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .SETTLE(1), .RECHECK_PERIOD(100)) dut1 (
    .clk(clk), .reset(rst1), .sid_address(sa1), .sid_readdata(rd1),
    .host_read(hrd1), .host_address(haddr1), .host_waitrequest(hwait1),
    .host_readdatavalid(hrdv1), .host_readdata(hrdata1), .start(start1),
    .busy(busy1), .done(done1), .checked(checked1), .id_ok(idok1), .ts_ok(tsok1),
    .mismatch(mism1), .id_value(idv1), .ts_value(tsv1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dcnt;
    int bcnt;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    hrd0 = 1'b0; haddr0 = 1'b0; hrd1 = 1'b0; haddr1 = 1'b0;
    id0w = EXP_ID; ts0w = EXP_TS;
    repeat (3) tick();

    // reset state (check_req is pending, so the host is stalled)
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_checked", checked0, 0);
    chk("rst_mismatch", mism0, 0);
    chk("rst_waitreq", hwait0, 1);
    chk("rst_sid_address", sa0, 0);
    chk("rst_rdvalid", hrdv0, 0);
    chk("rst_id_value", idv0, 0);

    // 1: automatic check after reset, done in 5th post-reset cycle
    rst0 = 1'b0; #1;
    chk("t1_c1_busy", busy0, 0);
    tick(); chk("t1_c2_busy", busy0, 1);
    tick(); chk("t1_c3_busy", busy0, 1);
    tick(); chk("t1_c4_busy", busy0, 1); chk("t1_c4_done", done0, 0);
    tick(); chk("t1_c5_done", done0, 1); chk("t1_c5_busy", busy0, 0);
    chk("t1_id_ok", idok0, 1); chk("t1_ts_ok", tsok0, 1);
    chk("t1_checked", checked0, 1); chk("t1_mismatch", mism0, 0);
    chk("t1_id_value", idv0, EXP_ID); chk("t1_ts_value", tsv0, EXP_TS);
    tick(); chk("t1_done_pulse", done0, 0);

    // 2: wrong ID word
    id0w = 32'd1; start0 = 1'b1;
    tick(); start0 = 1'b0; chk("t2_busy_t1", busy0, 1);
    tick(); tick(); chk("t2_busy_t3", busy0, 1);
    tick(); chk("t2_done", done0, 1);
    chk("t2_id_ok", idok0, 0); chk("t2_ts_ok", tsok0, 1);
    chk("t2_mismatch", mism0, 1); chk("t2_id_value", idv0, 1);
    tick(); id0w = EXP_ID;

    // 3: host reads while idle, back to back
    hrd0 = 1'b1; haddr0 = 1'b1; #1;
    chk("t3_accept_waitreq", hwait0, 0);
    tick(); hrd0 = 1'b0;
    chk("t3_hostrd_waitreq", hwait0, 1); chk("t3_early_rdvalid", hrdv0, 0);
    tick(); chk("t3_rdvalid", hrdv0, 1); chk("t3_rdata", hrdata0, EXP_TS);
    chk("t3_sid_addr_hold", sa0, 1);
    hrd0 = 1'b1; haddr0 = 1'b0; #1;
    chk("t3_b2b_waitreq", hwait0, 0);
    tick(); hrd0 = 1'b0;
    tick(); chk("t3_b2b_rdvalid", hrdv0, 1); chk("t3_b2b_rdata", hrdata0, EXP_ID);
    tick(); chk("t3_rdvalid_pulse", hrdv0, 0);

    // 4: start and host read together: check first, host stalled through COMPARE
    start0 = 1'b1; hrd0 = 1'b1; haddr0 = 1'b1; #1;
    chk("t4_k0_waitreq", hwait0, 1);
    tick(); start0 = 1'b0;
    chk("t4_k1_busy", busy0, 1); chk("t4_k1_waitreq", hwait0, 1);
    tick(); chk("t4_k2_waitreq", hwait0, 1);
    tick(); chk("t4_k3_waitreq", hwait0, 1); chk("t4_k3_rdvalid", hrdv0, 0);
    tick(); chk("t4_done", done0, 1); chk("t4_accept_waitreq", hwait0, 0);
    chk("t4_mismatch", mism0, 0);
    tick(); hrd0 = 1'b0; chk("t4_k5_rdvalid", hrdv0, 0);
    tick(); chk("t4_rdvalid", hrdv0, 1); chk("t4_rdata", hrdata0, EXP_TS);
    tick();

    // 5: start, then two starts during busy -> exactly one extra check
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      start0 = (i == 0) || (i == 2) || (i == 3);
      tick();
      if (done0) dcnt++;
      if (busy0) bcnt++;
    end
    start0 = 1'b0;
    chk("t5_done_pulses", dcnt, 2);
    chk("t5_busy_cycles", bcnt, 6);

    // 6: periodic recheck, then reset in RD_TS aborts the check
    rst1 = 1'b0;
    repeat (4) tick();
    chk("t6_first_done", done1, 1);
    chk("t6_checked", checked1, 1); chk("t6_mismatch", mism1, 0);
    chk("t6_id_ok", idok1, 1); chk("t6_ts_ok", tsok1, 1);
    chk("t6_id_value", idv1, EXP_ID); chk("t6_ts_value", tsv1, EXP_TS);
    chk("t6_rdvalid", hrdv1, 0); chk("t6_rdata", hrdata1, 0);
    chk("t6_waitreq", hwait1, 0);
    n = 0;
    while (n < 200 && !busy1) begin
      tick();
      n++;
    end
    chk("t6_period", n, 100);
    tick(); chk("t6_rd_ts_busy", busy1, 1);
    rst1 = 1'b1;
    tick(); chk("t6_abort_done", done1, 0); chk("t6_abort_busy", busy1, 0);
    chk("t6_abort_checked", checked1, 0); chk("t6_abort_sid_addr", sa1, 0);
    chk("t6_abort_waitreq", hwait1, 1);
    tick(); chk("t6_abort_done2", done1, 0);
    rst1 = 1'b0; #1;
    chk("t6_r1_busy", busy1, 0);
    tick(); chk("t6_restart_busy", busy1, 1);
    tick(); tick();
    tick(); chk("t6_restart_done", done1, 1); chk("t6_restart_checked", checked1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
